// File: rtl/toy_stu_sbuf.sv
// toy_stu_sbuf: store unit with an in-order circular store buffer.
// Computes the effective address, byte strobe and lane-shifted data for each
// store. Each store waits in the buffer until the ROB commits it. It then
// drains to the memory port over a valid/ready handshake. A flush discards
// every store that has not been committed yet.
// Optional feature macro: TOY_STU_FWD_EN adds a store-to-load forwarding
// lookup port (fwd_req_addr / fwd_hit / fwd_data / fwd_strb).
module toy_stu_sbuf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int LSID_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_store_vld,
  output logic                      s_store_rdy,
  input  logic [ADDR_WIDTH-1:0]     s_store_base,
  input  logic [ADDR_WIDTH-1:0]     s_store_imm,
  input  logic [DATA_WIDTH-1:0]     s_store_data,
  input  logic [2:0]                s_store_funct3,
  input  logic [LSID_WIDTH-1:0]     s_store_lsid,
  input  logic                      commit_vld,
  input  logic                      flush,
  output logic                      m_mem_vld,
  input  logic                      m_mem_rdy,
  output logic [ADDR_WIDTH-1:0]     m_mem_addr,
  output logic [DATA_WIDTH-1:0]     m_mem_data,
  output logic [DATA_WIDTH/8-1:0]   m_mem_strb,
  output logic [LSID_WIDTH-1:0]     m_mem_lsid,
  output logic                      m_excp_vld,
  output logic [LSID_WIDTH-1:0]     m_excp_lsid,
  output logic [$clog2(DEPTH):0]    sbuf_cnt
`ifdef TOY_STU_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]     fwd_req_addr,
  output logic                      fwd_hit,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic [DATA_WIDTH/8-1:0]   fwd_strb
`endif
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(DEPTH);
  localparam int PTRW = IW + 1;

  // Buffer storage, indexed by the low pointer bits
  logic [ADDR_WIDTH-1:0] r_addrMem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dataMem [DEPTH];
  logic [NB-1:0]         r_strbMem [DEPTH];
  logic [LSID_WIDTH-1:0] r_lsidMem [DEPTH];

  // Pointers carry an extra wrap bit so that full and empty can be told apart
  logic [PTRW-1:0] r_wrPtr;
  logic [PTRW-1:0] r_cmtPtr;
  logic [PTRW-1:0] r_rdPtr;
  logic [PTRW-1:0] r_cnt;
  logic            r_excpVld;
  logic [LSID_WIDTH-1:0] r_excpLsid;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_alignedAddr;
  logic [OFFW-1:0]       w_off;
  logic [3:0]            w_lowMask;
  logic [7:0]            w_strbBase;
  logic [NB-1:0]         w_strb;
  logic [DATA_WIDTH-1:0] w_shData;
  logic                  w_legal;
  logic                  w_misalign;
  logic                  w_ok;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_enq;
  logic                  w_excp;
  logic                  w_cmtDo;
  logic                  w_drain;
  logic [PTRW-1:0]       w_cmtNext;
  logic [PTRW-1:0]       w_rdNext;
  logic [PTRW-1:0]       w_wrNext;

  // Decode the incoming store: address, size, strobe, lane shift and legality
  always_comb begin
    w_addr        = s_store_base + s_store_imm;
    w_off         = w_addr[OFFW-1:0];
    w_alignedAddr = {w_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    w_lowMask     = 4'd0;
    w_strbBase    = 8'h00;
    w_legal       = 1'b0;
    case (s_store_funct3)
      3'b000: begin w_lowMask = 4'd0; w_strbBase = 8'h01; w_legal = 1'b1; end
      3'b001: begin w_lowMask = 4'd1; w_strbBase = 8'h03; w_legal = 1'b1; end
      3'b010: begin w_lowMask = 4'd3; w_strbBase = 8'h0F; w_legal = 1'b1; end
      3'b011: begin w_lowMask = 4'd7; w_strbBase = 8'hFF; w_legal = (DATA_WIDTH == 64); end
      default: begin w_lowMask = 4'd0; w_strbBase = 8'h00; w_legal = 1'b0; end
    endcase
    w_misalign = (w_off & w_lowMask[OFFW-1:0]) != '0;
    w_ok       = w_legal & ~w_misalign;
    w_strb     = w_strbBase[NB-1:0] << w_off;
    w_shData   = s_store_data << {w_off, 3'b000};
  end

  // Handshake, commit, drain and next-pointer computation
  always_comb begin
    w_full      = (r_wrPtr - r_rdPtr) == PTRW'(DEPTH);
    s_store_rdy = ~w_full & ~flush;
    w_accept    = s_store_vld & s_store_rdy;
    w_enq       = w_accept & w_ok;
    w_excp      = w_accept & ~w_ok;
    w_cmtDo     = commit_vld & (r_cmtPtr != r_wrPtr);
    w_cmtNext   = r_cmtPtr + PTRW'(w_cmtDo);
    m_mem_vld   = r_rdPtr != r_cmtPtr;
    w_drain     = m_mem_vld & m_mem_rdy;
    w_rdNext    = r_rdPtr + PTRW'(w_drain);
    w_wrNext    = flush ? w_cmtNext : (r_wrPtr + PTRW'(w_enq));
  end

  assign m_mem_addr  = r_addrMem[r_rdPtr[IW-1:0]];
  assign m_mem_data  = r_dataMem[r_rdPtr[IW-1:0]];
  assign m_mem_strb  = r_strbMem[r_rdPtr[IW-1:0]];
  assign m_mem_lsid  = r_lsidMem[r_rdPtr[IW-1:0]];
  assign m_excp_vld  = r_excpVld;
  assign m_excp_lsid = r_excpLsid;
  assign sbuf_cnt    = r_cnt;

  // Advance the write, commit and read pointers and the occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr  <= '0;
      r_cmtPtr <= '0;
      r_rdPtr  <= '0;
      r_cnt    <= '0;
    end else begin
      r_wrPtr  <= w_wrNext;
      r_cmtPtr <= w_cmtNext;
      r_rdPtr  <= w_rdNext;
      r_cnt    <= w_wrNext - w_rdNext;
    end
  end

  // Write a legal accepted store into the entry at the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addrMem[i] <= '0;
        r_dataMem[i] <= '0;
        r_strbMem[i] <= '0;
        r_lsidMem[i] <= '0;
      end
    end else if (w_enq) begin
      r_addrMem[r_wrPtr[IW-1:0]] <= w_alignedAddr;
      r_dataMem[r_wrPtr[IW-1:0]] <= w_shData;
      r_strbMem[r_wrPtr[IW-1:0]] <= w_strb;
      r_lsidMem[r_wrPtr[IW-1:0]] <= s_store_lsid;
    end
  end

  // Raise a one-cycle exception for a misaligned or illegal accepted store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_excpVld  <= 1'b0;
      r_excpLsid <= '0;
    end else begin
      r_excpVld <= w_excp;
      if (w_excp) begin
        r_excpLsid <= s_store_lsid;
      end
    end
  end

`ifdef TOY_STU_FWD_EN
  logic [PTRW-1:0]       w_occ;
  logic [ADDR_WIDTH-1:0] w_fwdAligned;
  logic [IW-1:0]         w_fwdIdx;

  // Scan live entries oldest to youngest so the youngest match wins
  always_comb begin
    w_occ        = r_wrPtr - r_rdPtr;
    w_fwdAligned = {fwd_req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    w_fwdIdx     = '0;
    fwd_hit      = 1'b0;
    fwd_data     = '0;
    fwd_strb     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fwdIdx = r_rdPtr[IW-1:0] + IW'(k);
      if ((PTRW'(k) < w_occ) && (r_addrMem[w_fwdIdx] == w_fwdAligned)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_dataMem[w_fwdIdx];
        fwd_strb = r_strbMem[w_fwdIdx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_toy_stu_sbuf.sv
// tb_toy_stu_sbuf: directed, table-driven bench for toy_stu_sbuf at the
// default 32-bit configuration, plus hand-written full/wrap, flush and
// (with TOY_STU_FWD_EN) forwarding sequences.
module tb_toy_stu_sbuf;

  logic        clk;
  logic        rst_n;
  logic        s_store_vld;
  logic        s_store_rdy;
  logic [31:0] s_store_base;
  logic [31:0] s_store_imm;
  logic [31:0] s_store_data;
  logic [2:0]  s_store_funct3;
  logic [3:0]  s_store_lsid;
  logic        commit_vld;
  logic        flush;
  logic        m_mem_vld;
  logic        m_mem_rdy;
  logic [31:0] m_mem_addr;
  logic [31:0] m_mem_data;
  logic [3:0]  m_mem_strb;
  logic [3:0]  m_mem_lsid;
  logic        m_excp_vld;
  logic [3:0]  m_excp_lsid;
  logic [3:0]  sbuf_cnt;
`ifdef TOY_STU_FWD_EN
  logic [31:0] fwd_req_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_strb;
`endif

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [3:0]  lsid;
    logic        expExcp;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [3:0]  expStrb;
  } vec_t;

  vec_t vecs[10];

  toy_stu_sbuf dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_store_vld(s_store_vld),
    .s_store_rdy(s_store_rdy),
    .s_store_base(s_store_base),
    .s_store_imm(s_store_imm),
    .s_store_data(s_store_data),
    .s_store_funct3(s_store_funct3),
    .s_store_lsid(s_store_lsid),
    .commit_vld(commit_vld),
    .flush(flush),
    .m_mem_vld(m_mem_vld),
    .m_mem_rdy(m_mem_rdy),
    .m_mem_addr(m_mem_addr),
    .m_mem_data(m_mem_data),
    .m_mem_strb(m_mem_strb),
    .m_mem_lsid(m_mem_lsid),
    .m_excp_vld(m_excp_vld),
    .m_excp_lsid(m_excp_lsid),
    .sbuf_cnt(sbuf_cnt)
`ifdef TOY_STU_FWD_EN
    ,
    .fwd_req_addr(fwd_req_addr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data),
    .fwd_strb(fwd_strb)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic driveStore(input logic [31:0] base, input logic [31:0] imm, input logic [31:0] data,
                            input logic [2:0] f3, input logic [3:0] lsid);
    s_store_vld    = 1'b1;
    s_store_base   = base;
    s_store_imm    = imm;
    s_store_data   = data;
    s_store_funct3 = f3;
    s_store_lsid   = lsid;
  endtask

  // One store from the table: enqueue, commit, check drain outputs, drain
  task automatic applyStimulus(input vec_t v);
    driveStore(v.base, v.imm, v.data, v.f3, v.lsid);
    step;
    s_store_vld = 1'b0;
    if (v.expExcp) begin
      checkOutput("excpVld", 64'(m_excp_vld), 64'd1);
      checkOutput("excpLsid", 64'(m_excp_lsid), 64'(v.lsid));
      checkOutput("excpCnt", 64'(sbuf_cnt), 64'd0);
      step;
      checkOutput("excpOneCycle", 64'(m_excp_vld), 64'd0);
      checkOutput("excpNoDrain", 64'(m_mem_vld), 64'd0);
    end else begin
      checkOutput("cntAfterEnq", 64'(sbuf_cnt), 64'd1);
      checkOutput("vldBeforeCommit", 64'(m_mem_vld), 64'd0);
      checkOutput("noExcp", 64'(m_excp_vld), 64'd0);
      commit_vld = 1'b1;
      step;
      commit_vld = 1'b0;
      checkOutput("vldAfterCommit", 64'(m_mem_vld), 64'd1);
      checkOutput("memAddr", 64'(m_mem_addr), 64'(v.expAddr));
      checkOutput("memData", 64'(m_mem_data), 64'(v.expData));
      checkOutput("memStrb", 64'(m_mem_strb), 64'(v.expStrb));
      checkOutput("memLsid", 64'(m_mem_lsid), 64'(v.lsid));
      m_mem_rdy = 1'b1;
      step;
      m_mem_rdy = 1'b0;
      checkOutput("vldAfterDrain", 64'(m_mem_vld), 64'd0);
      checkOutput("cntAfterDrain", 64'(sbuf_cnt), 64'd0);
    end
  endtask

  initial begin
    int sent;
    int drained;
    int cyc;
    int flushDrains;
    logic [31:0] ea;

    vecs[0] = '{32'h100,      32'h4,        32'hDEADBEEF, 3'b010, 4'd3, 1'b0, 32'h104,  32'hDEADBEEF, 4'hF};
    vecs[1] = '{32'h203,      32'h0,        32'h000000AB, 3'b000, 4'd1, 1'b0, 32'h200,  32'hAB000000, 4'h8};
    vecs[2] = '{32'h202,      32'h0,        32'h00001234, 3'b001, 4'd2, 1'b0, 32'h200,  32'h12340000, 4'hC};
    vecs[3] = '{32'h102,      32'h0,        32'h00000000, 3'b010, 4'd5, 1'b1, 32'h0,    32'h0,        4'h0};
    vecs[4] = '{32'h100,      32'h0,        32'h00000000, 3'b011, 4'd6, 1'b1, 32'h0,    32'h0,        4'h0};
    vecs[5] = '{32'h1001,     32'hFFFFFFFF, 32'h123456CD, 3'b000, 4'd4, 1'b0, 32'h1000, 32'h123456CD, 4'h1};
    vecs[6] = '{32'h5,        32'h0,        32'h00000000, 3'b001, 4'd7, 1'b1, 32'h0,    32'h0,        4'h0};
    vecs[7] = '{32'h1,        32'h0,        32'hFFFFFF77, 3'b000, 4'd8, 1'b0, 32'h0,    32'hFFFF7700, 4'h2};
    vecs[8] = '{32'h40,       32'h0,        32'h00000000, 3'b100, 4'd9, 1'b1, 32'h0,    32'h0,        4'h0};
    vecs[9] = '{32'hFFFFFFFE, 32'h4,        32'h0000BEEF, 3'b001, 4'hA, 1'b0, 32'h0,    32'hBEEF0000, 4'hC};

    rst_n = 1'b0;
    s_store_vld = 1'b0;
    s_store_base = '0;
    s_store_imm = '0;
    s_store_data = '0;
    s_store_funct3 = '0;
    s_store_lsid = '0;
    commit_vld = 1'b0;
    flush = 1'b0;
    m_mem_rdy = 1'b0;
`ifdef TOY_STU_FWD_EN
    fwd_req_addr = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstRdy", 64'(s_store_rdy), 64'd1);
    checkOutput("rstMemVld", 64'(m_mem_vld), 64'd0);
    checkOutput("rstExcp", 64'(m_excp_vld), 64'd0);
    checkOutput("rstCnt", 64'(sbuf_cnt), 64'd0);
    checkOutput("rstData", {m_mem_addr, m_mem_data}, 64'd0);
    rst_n = 1'b1;
    step;

    $display("[TB] commit on empty buffer is ignored");
    commit_vld = 1'b1;
    step;
    commit_vld = 1'b0;
    checkOutput("emptyCommitVld", 64'(m_mem_vld), 64'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] fill, full, then wrap-around streaming");
    for (int i = 0; i < 8; i++) begin
      driveStore(32'h400, 32'(i * 4), 32'hA0000000 | 32'(i), 3'b010, 4'(i));
      step;
    end
    s_store_vld = 1'b0;
    checkOutput("fullRdy", 64'(s_store_rdy), 64'd0);
    checkOutput("fullCnt", 64'(sbuf_cnt), 64'd8);
    checkOutput("fullNoVld", 64'(m_mem_vld), 64'd0);
    commit_vld = 1'b1;
    repeat (8) step;
    commit_vld = 1'b0;
    checkOutput("headAfterCommit", {31'd0, m_mem_vld, m_mem_lsid, m_mem_addr}, {31'd0, 1'b1, 4'd0, 32'h400});
    step;
    checkOutput("headHold", {m_mem_lsid, m_mem_data, m_mem_addr[27:0]}, {4'd0, 32'hA0000000, 28'h400});
    m_mem_rdy = 1'b1;
    step;
    m_mem_rdy = 1'b0;
    checkOutput("rdyAfterDrain", 64'(s_store_rdy), 64'd1);
    checkOutput("cntAfterOneDrain", 64'(sbuf_cnt), 64'd7);

    sent = 8;
    drained = 1;
    cyc = 0;
    commit_vld = 1'b1;
    m_mem_rdy = 1'b1;
    while (drained < 28 && cyc < 300) begin
      if (sent < 28) begin
        driveStore(32'h400, 32'(sent * 4), 32'hA0000000 | 32'(sent), 3'b010, 4'(sent));
      end else begin
        s_store_vld = 1'b0;
      end
      #1;
      if (m_mem_vld) begin
        ea = 32'h400 + 32'(drained * 4);
        checkOutput("wrapOrder", {28'd0, m_mem_lsid, m_mem_addr}, {28'd0, 4'(drained), ea});
        drained++;
      end
      if (s_store_vld && s_store_rdy) begin
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    s_store_vld = 1'b0;
    commit_vld = 1'b0;
    m_mem_rdy = 1'b0;
    checkOutput("wrapAllDrained", 64'(drained), 64'd28);
    step;
    checkOutput("wrapEmptyCnt", 64'(sbuf_cnt), 64'd0);
    checkOutput("wrapEmptyVld", 64'(m_mem_vld), 64'd0);

    $display("[TB] commit plus flush in the same cycle");
    for (int i = 1; i <= 4; i++) begin
      driveStore(32'h500, 32'(i * 4), 32'(i), 3'b010, 4'(i));
      step;
    end
    s_store_vld = 1'b0;
    checkOutput("preFlushCnt", 64'(sbuf_cnt), 64'd4);
    commit_vld = 1'b1;
    step;
    flush = 1'b1;
    driveStore(32'h600, 32'h0, 32'hFFFFFFFF, 3'b010, 4'hF);
    #1;
    checkOutput("flushRdy", 64'(s_store_rdy), 64'd0);
    step;
    flush = 1'b0;
    commit_vld = 1'b0;
    s_store_vld = 1'b0;
    checkOutput("postFlushCnt", 64'(sbuf_cnt), 64'd2);
    flushDrains = 0;
    m_mem_rdy = 1'b1;
    commit_vld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (m_mem_vld) begin
        flushDrains++;
        checkOutput("flushDrainLsid", 64'(m_mem_lsid), 64'(flushDrains));
      end
      step;
    end
    m_mem_rdy = 1'b0;
    commit_vld = 1'b0;
    checkOutput("flushDrainCount", 64'(flushDrains), 64'd2);
    checkOutput("flushEndCnt", 64'(sbuf_cnt), 64'd0);

`ifdef TOY_STU_FWD_EN
    $display("[TB] store-to-load forwarding");
    driveStore(32'h300, 32'h0, 32'h11, 3'b010, 4'd1);
    step;
    driveStore(32'h300, 32'h0, 32'h22, 3'b010, 4'd2);
    step;
    s_store_vld = 1'b0;
    fwd_req_addr = 32'h300;
    #1;
    checkOutput("fwdHit", 64'(fwd_hit), 64'd1);
    checkOutput("fwdData", 64'(fwd_data), 64'h22);
    checkOutput("fwdStrb", 64'(fwd_strb), 64'hF);
    commit_vld = 1'b1;
    m_mem_rdy = 1'b1;
    repeat (6) step;
    commit_vld = 1'b0;
    m_mem_rdy = 1'b0;
    checkOutput("fwdMissAfterDrain", 64'(fwd_hit), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
